uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter (baud-tick driven frame serializer) between NREQ byte sources.
//  Round-robin arbitration with per-requester message lock, so a multi-byte message is never interleaved.
//  Sits between client logic and the transmitter; sequences tx_start against the transmitter's tx_busy.
// PARAMETERS
//  NREQ     4    number of requesters (2..8)
//  DW       8    data byte width
//  LOCK_TO  1024 idle cycles a locked requester may stall before lock is force-released (>=1)
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        reset; one clock; reset is asynchronous and active-low
//  req_valid  in   NREQ     requester i has a byte; held until accepted
//  req_data   in   NREQ*DW  byte of requester i at [i*DW +: DW]
//  req_last   in   NREQ     byte is last of message (releases lock)
//  req_ready  out  NREQ     accept strobe; transfer when req_valid[i] & req_ready[i]
//  grant      out  NREQ     one-hot current owner, 0 when none
//  tx_data    out  DW       byte to transmitter, stable while tx_start or tx_busy
//  tx_start   out  1        level request to transmitter; held until tx_busy seen high
//  tx_busy    in   1        transmitter frame in progress
//  active     out  1        arbiter owns transmitter (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, req_ready=0, tx_start=0, tx_data=0, active=0, rr_ptr=0, lock=0, timer=0.
//  States: IDLE, SEND, START, WAIT_DONE.
//  IDLE: if |req_valid && !tx_busy: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1.. mod NREQ;
//    grant<=onehot(winner), ->SEND. Else stay.
//  SEND: req_ready[g]=req_valid[g] (combinational, only granted bit). On transfer: tx_data<=req_data[g],
//    lock<=!req_last[g], tx_start<=1, timer<=0, ->START.
//    No transfer and lock=1: timer++; timer==LOCK_TO-1 -> release (see below) instead.
//  START: tx_start held 1 until tx_busy==1 sampled; then tx_start<=0, ->WAIT_DONE.
//  WAIT_DONE: wait tx_busy==0. Then lock=1 -> SEND (same grant); lock=0 -> release.
//  Release: grant<=0, lock<=0, rr_ptr<=(g+1) mod NREQ, ->IDLE. Released requester lowest priority next round.
//  Latency: req_valid high in IDLE at edge N -> grant at N+1, req_ready same cycle, tx_start high after N+2.
//  Min gap between bytes of one message: 1 cycle (SEND) after tx_busy falls.
//  Boundaries:
//   - requests arriving during SEND/START/WAIT_DONE of another owner wait; evaluated only in IDLE.
//   - granted req_valid dropped in first SEND (lock=0): stay in SEND; no timeout when unlocked
//     (protocol violation, valid must hold). Timer applies only while lock=1.
//   - tx_busy already high in IDLE: no grant until it falls.
//   - rr_ptr wraps NREQ-1 -> 0.
//   - rst_n low mid-frame: all outputs to reset values immediately; transmitter owns its own recovery.
//   - exactly one bit of grant/req_ready ever set; req_ready never high outside SEND.
// TESTING
//  1 single: req0 valid 0x55 last=1 -> grant=0001 next cycle, one ready pulse, tx_start until busy, tx_data=0x55, back to IDLE.
//  2 round robin: req0..3 all valid, last=1 -> bytes sent in order 0,1,2,3,0; no requester served twice before others.
//  3 lock: req1 sends 0xA1,0xA2,0xA3(last) while req2 valid -> tx sequence A1,A2,A3 then req2's byte.
//  4 lock timeout LOCK_TO=16: req0 sends byte last=0 then drops valid -> 16 SEND cycles then grant=0, req3 served.
//  5 busy handshake: tx_busy delayed 50 cycles after tx_start -> tx_start stays high 50 cycles, tx_data stable throughout.
//  6 reset mid-op: rst_n low during WAIT_DONE -> all outputs 0 asynchronously; after release, grant resumes from req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources,
// with a per-requester message lock and a stall timeout on the lock.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int LOCK_TO = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    grant,
  output logic [DW-1:0]      tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  output logic               active
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(LOCK_TO + 1);

  typedef enum logic [1:0] {IDLE, SEND, START, WAIT_DONE} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;

  logic [2*NREQ-1:0] dbl;
  logic [PW-1:0]     off, win_idx, g_idx, nxt_ptr;
  logic [DW-1:0]     g_data;
  logic              g_last, xfer;

  // Rotate the request vector so rr_ptr sits at bit 0; the lowest set bit
  // of the rotated vector is the winner's offset from rr_ptr.
  always_comb begin
    int w;
    int nx;
    dbl = {req_valid, req_valid} >> rr_ptr_q;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (dbl[k]) off = PW'(k);
    w = int'(rr_ptr_q) + int'(off);
    if (w >= NREQ) w = w - NREQ;
    win_idx = PW'(w);

    g_idx  = '0;
    g_data = '0;
    g_last = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (grant_q[i]) begin
        g_idx  = PW'(i);
        g_data = req_data[i*DW +: DW];
        g_last = req_last[i];
      end
    nx = int'(g_idx) + 1;
    if (nx == NREQ) nx = 0;
    nxt_ptr = PW'(nx);
  end

  assign req_ready = (state_q == SEND) ? (req_valid & grant_q) : '0;
  assign xfer      = |req_ready;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid && !tx_busy) begin
          for (int i = 0; i < NREQ; i++) grant_d[i] = (win_idx == PW'(i));
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          tx_data_d  = g_data;
          lock_d     = !g_last;
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = START;
        end else if (lock_q) begin
          if (timer_q == TW'(LOCK_TO - 1)) begin
            grant_d  = '0;
            lock_d   = 1'b0;
            timer_d  = '0;
            rr_ptr_d = nxt_ptr;
            state_d  = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (lock_q) begin
            state_d = SEND;
          end else begin
            grant_d  = '0;
            timer_d  = '0;
            rr_ptr_d = nxt_ptr;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      timer_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      timer_q    <= timer_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign active   = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester queues, a delayed-busy transmitter model,
// a transaction-level arbitration/scoreboard monitor and directed scenarios.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4, DW = 8, LOCK_TO = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid = '0, req_last = '0, req_ready, grant;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [DW-1:0]      tx_data;
  logic               tx_start, tx_busy, active;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .LOCK_TO(LOCK_TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .active(active));

  int checks = 0, passed = 0;
  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Requesters: each holds a queue of {last,data}; head is presented until accepted.
  logic [DW:0]     rq[NREQ][$];
  logic [NREQ-1:0] xfer_seen = '0;
  task automatic push(int r, logic [DW-1:0] d, logic l);
    rq[r].push_back({l, d});
  endtask
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_seen[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      req_valid[i] = (rq[i].size() > 0);
      req_data[i*DW +: DW] = req_valid[i] ? rq[i][0][DW-1:0] : '0;
      req_last[i] = req_valid[i] ? rq[i][0][DW] : 1'b0;
    end
  end

  // Transmitter: answers tx_start with busy after tx_dly samples, frame lasts tx_len.
  int   tx_dly = 2, tx_len = 5, dcnt = 0, fcnt = 0;
  logic busy_m = 1'b0, busy_nxt = 1'b0, busy_force = 1'b0;
  assign tx_busy = busy_m | busy_force;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_nxt = 1'b0; dcnt = 0; fcnt = 0;
    end else if (fcnt > 0) begin
      fcnt--;
      if (fcnt == 0) busy_nxt = 1'b0;
    end else if (tx_start && !tx_busy) begin
      dcnt++;
      if (dcnt >= tx_dly) begin busy_nxt = 1'b1; fcnt = tx_len; dcnt = 0; end
    end
  end
  always @(posedge clk) begin #1; busy_m = rst_n ? busy_nxt : 1'b0; end

  // Arbitration model: winner is the first valid requester at or after the pointer;
  // the pointer moves past the owner whenever ownership ends.
  function automatic int rr_pick(int ptr, logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction
  function automatic int oh_idx(logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) if (v[k]) return k;
    return 0;
  endfunction

  int              m_ptr = 0, pk;
  logic [NREQ-1:0] p_grant = '0, p_valid = '0;
  logic            p_busy = 1'b0, p_start = 1'b0;
  logic [DW-1:0]   p_txd = '0;
  logic [DW-1:0]   expq[$], txlog[$], explog[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr = 0; expq.delete(); p_grant = '0; p_valid = '0;
      p_busy = 1'b0; p_start = 1'b0; xfer_seen = '0;
    end else begin
      chk("grant_onehot0", $onehot0(grant), 1);
      chk("ready_outside_grant", req_ready & ~grant, 0);
      chk("ready_without_valid", req_ready & ~req_valid, 0);
      chk("active_vs_grant", active, |grant);
      if (tx_start) chk("start_while_active", active, 1);
      if (p_grant == 0 && grant != 0) begin
        pk = rr_pick(m_ptr, p_valid);
        chk("grant_pick", grant, (pk < 0) ? 0 : (1 << pk));
        chk("grant_while_busy", p_busy, 0);
      end
      if (p_grant != 0 && grant != 0) chk("grant_hold", grant, p_grant);
      if (p_grant != 0 && grant == 0) m_ptr = (oh_idx(p_grant) + 1) % NREQ;
      xfer_seen = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) if (xfer_seen[i]) expq.push_back(req_data[i*DW +: DW]);
      if ((p_start || p_busy) && (tx_start || tx_busy)) chk("tx_data_stable", tx_data, p_txd);
      if (!p_busy && tx_busy && tx_start) begin
        txlog.push_back(tx_data);
        if (expq.size() == 0) begin
          checks++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else chk("tx_byte", tx_data, expq.pop_front());
      end
      p_grant = grant; p_valid = req_valid; p_busy = tx_busy; p_start = tx_start; p_txd = tx_data;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    busy_force = 1'b0; tx_dly = 2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    txlog.delete();
  endtask

  task automatic wait_idle(string nm);
    bit done = 0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      done = !active && !tx_busy && !tx_start && req_valid == 0 &&
             rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0;
    end
    if (!done) begin checks++; $display("FAIL %s_timeout: got busy expected idle", nm); end
  endtask

  task automatic check_log(string nm);
    chk({nm, "_count"}, txlog.size(), explog.size());
    for (int i = 0; i < txlog.size() && i < explog.size(); i++) chk(nm, txlog[i], explog[i]);
  endtask

  int  cnt;
  bit  seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_active", active, 0);
    rst_n = 1'b1;

    // single byte: grant one cycle after valid is seen, then tx_start with the byte
    push(0, 8'h55, 1'b1);
    @(negedge clk); chk("t1_no_grant_yet", grant, 0);
    @(negedge clk); chk("t1_grant", grant, 4'b0001); chk("t1_ready", req_ready, 4'b0001);
    chk("t1_start_low", tx_start, 0);
    @(negedge clk); chk("t1_start", tx_start, 1); chk("t1_data", tx_data, 8'h55);
    chk("t1_ready_off", req_ready, 0);
    wait_idle("t1");
    explog = '{8'h55}; check_log("t1_log");

    // round robin: requester 0 has two messages, served again only after 1..3
    do_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    wait_idle("t2");
    explog = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14}; check_log("t2_log");

    // lock: requester 1's three-byte message is not interleaved with requester 2
    do_reset();
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    push(2, 8'hB2, 1'b1);
    wait_idle("t3");
    explog = '{8'hA1, 8'hA2, 8'hA3, 8'hB2}; check_log("t3_log");

    // lock timeout: one sample where busy has fallen but the owner is still waiting,
    // then LOCK_TO stalled SEND cycles before the grant drops
    do_reset();
    push(0, 8'h40, 1'b0); push(3, 8'h43, 1'b1);
    cnt = 0; seen = 0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      if (txlog.size() >= 1 && !tx_busy) begin
        if (!active) seen = 1;
        else if (!tx_start && grant == 4'b0001) cnt++;
      end
    end
    chk("t4_stall_cycles", cnt, 17);
    chk("t4_released_grant", grant, 0);
    wait_idle("t4");
    explog = '{8'h40, 8'h43}; check_log("t4_log");

    // slow busy: tx_start held until busy is seen, data stable throughout
    do_reset();
    tx_dly = 49;
    push(2, 8'h5A, 1'b1);
    cnt = 0; seen = 0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      if (tx_start) cnt++;
      else if (cnt > 0) seen = 1;
    end
    chk("t5_start_cycles", cnt, 50);
    wait_idle("t5");
    explog = '{8'h5A}; check_log("t5_log");

    // busy already high while idle: no grant until it falls
    do_reset();
    busy_force = 1'b1;
    push(1, 8'h77, 1'b1);
    seen = 0;
    repeat (10) begin @(negedge clk); if (grant != 0) seen = 1; end
    chk("t7_no_grant_while_busy", seen, 0);
    busy_force = 1'b0;
    wait_idle("t7");
    explog = '{8'h77}; check_log("t7_log");

    // reset during a frame: outputs clear immediately, pointer restarts at 0
    do_reset();
    push(1, 8'h61, 1'b1);
    seen = 0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge clk);
      seen = active && tx_busy && !tx_start;
    end
    chk("t6_reached_wait", seen, 1);
    #2 rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    #1;
    chk("t6_grant", grant, 0); chk("t6_ready", req_ready, 0);
    chk("t6_start", tx_start, 0); chk("t6_data", tx_data, 0); chk("t6_active", active, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txlog.delete();
    push(2, 8'h72, 1'b1); push(0, 8'h70, 1'b1);
    seen = 0;
    for (int n = 0; n < 100 && !seen; n++) begin @(negedge clk); seen = (grant != 0); end
    chk("t6_first_grant", grant, 4'b0001);
    wait_idle("t6");
    explog = '{8'h70, 8'h72}; check_log("t6_log");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
